djb2_feeder: RTL and testbench

- Initiator for the djb2 hash core's cmd/data/busy interface.
- Accepts a byte stream framed by a last flag and packs up to four 7-bit characters per 28-bit word.
- Sequences the core's clear, enable and length command bits for each word, then returns the 32-bit digest with a valid/ready handshake.
- Sits between a stream source (DMA or AXI register front end) and the hash core; software no longer bit-bangs cmd.

---
 rtl/djb2_feeder_if.sv | 10 +
 rtl/djb2_feeder.sv | 164 ++++++++++++++++
 tb/tb_djb2_feeder.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/djb2_feeder_if.sv
// Command/data/busy bus between the djb2 feeder (master) and the djb2 hash core (slave).
interface djb2_feeder_if;
  logic [3:0]  hash_cmd;
  logic [27:0] hash_data;
  logic        hash_busy;
  logic [31:0] hash_value;

  modport master (output hash_cmd, hash_data, input  hash_busy, hash_value);
  modport slave  (input  hash_cmd, hash_data, output hash_busy, hash_value);
endinterface

// File: rtl/djb2_feeder.sv
// Packs a last-framed byte stream into 4x7-bit words, sequences the djb2 core's
// clear/enable/length commands per word and hands back the final digest.
module djb2_feeder #(
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [7:0]          s_data,
  input  logic                s_last,
  djb2_feeder_if.master       hif,
  output logic [31:0]         digest,
  output logic                digest_valid,
  input  logic                digest_ready,
  output logic                err_timeout,
  output logic                err_nonascii
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FILL, S_ISSUE, S_WAIT, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [27:0]   word_q, word_d;
  // Slot counter wraps 3->0 on the fourth byte; a word in flight is never empty,
  // so cnt_q-1 still yields the correct length field of 3.
  logic [1:0]    cnt_q, cnt_d;
  logic          last_q, last_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   digest_q, digest_d;
  logic          err_tmo_q, err_tmo_d;
  logic          err_na_q, err_na_d;

  logic [3:0]    cmd;
  logic [1:0]    len;
  logic          timeout_hit;

  assign len         = cnt_q - 2'd1;
  assign timeout_hit = (tmo_q == TW'(TIMEOUT - 1));

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    tmo_d        = tmo_q;
    digest_d     = digest_q;
    err_tmo_d    = err_tmo_q;
    err_na_d     = err_na_q;
    s_ready      = 1'b0;
    cmd          = 4'b0000;
    digest_valid = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (s_valid) state_d = S_CLEAR;
      end

      S_CLEAR: begin
        cmd       = 4'b1000;
        err_tmo_d = 1'b0;
        err_na_d  = 1'b0;
        word_d    = '0;
        cnt_d     = '0;
        last_d    = 1'b0;
        state_d   = S_FILL;
      end

      S_FILL: begin
        s_ready = 1'b1;
        if (s_valid) begin
          unique case (cnt_q)
            2'd0: word_d[6:0]   = s_data[6:0];
            2'd1: word_d[13:7]  = s_data[6:0];
            2'd2: word_d[20:14] = s_data[6:0];
            2'd3: word_d[27:21] = s_data[6:0];
          endcase
          if (s_data[7]) err_na_d = 1'b1;
          cnt_d = cnt_q + 2'd1;
          if (s_last) last_d = 1'b1;
          if (s_last || cnt_q == 2'd3) begin
            tmo_d   = '0;
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        cmd   = {2'b01, len};
        tmo_d = tmo_q + 1'b1;
        if (hif.hash_busy) begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end else if (timeout_hit) begin
          err_tmo_d = 1'b1;
          digest_d  = hif.hash_value;
          state_d   = S_DONE;
        end
      end

      S_WAIT: begin
        // Enable drops here so the core sees a fresh rising edge on the next word.
        cmd   = {2'b00, len};
        tmo_d = tmo_q + 1'b1;
        if (!hif.hash_busy) begin
          cnt_d  = '0;
          word_d = '0;
          if (last_q) begin
            digest_d = hif.hash_value;
            state_d  = S_DONE;
          end else begin
            state_d = S_FILL;
          end
        end else if (timeout_hit) begin
          err_tmo_d = 1'b1;
          digest_d  = hif.hash_value;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        digest_valid = 1'b1;
        if (digest_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its _d input regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      word_q    <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      tmo_q     <= '0;
      digest_q  <= '0;
      err_tmo_q <= 1'b0;
      err_na_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      tmo_q     <= tmo_d;
      digest_q  <= digest_d;
      err_tmo_q <= err_tmo_d;
      err_na_q  <= err_na_d;
    end
  end

  assign hif.hash_cmd  = cmd;
  assign hif.hash_data = word_q;
  assign digest        = digest_q;
  assign err_timeout   = err_tmo_q;
  assign err_nonascii  = err_na_q;

endmodule

// File: tb/tb_djb2_feeder.sv
// Directed bench for djb2_feeder with a behavioural djb2 core on the slave side
// of the command bus; digests are compared against hand-computed constants.
module tb_djb2_feeder;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'h00;
  logic        s_last = 1'b0;
  logic [31:0] digest;
  logic        digest_valid;
  logic        digest_ready = 1'b0;
  logic        err_timeout;
  logic        err_nonascii;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  djb2_feeder_if hif();

  djb2_feeder #(.TIMEOUT(TIMEOUT), .TW(7)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .hif          (hif),
    .digest       (digest),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .err_timeout  (err_timeout),
    .err_nonascii (err_nonascii)
  );

  // Core model: clear -> 5381; enable rising edge starts len+1 calc cycles,
  // each folding one 7-bit char as hash*33+c; busy spans the calc cycles.
  logic [31:0] core_hash = 32'd0;
  logic        core_busy = 1'b0;
  logic        core_en_q = 1'b0;
  logic [1:0]  core_idx  = 2'd0;
  logic        core_dead = 1'b0;
  logic [6:0]  core_char;

  always_comb begin
    core_char = hif.hash_data[6:0];
    case (core_idx)
      2'd1: core_char = hif.hash_data[13:7];
      2'd2: core_char = hif.hash_data[20:14];
      2'd3: core_char = hif.hash_data[27:21];
      default: core_char = hif.hash_data[6:0];
    endcase
  end

  always @(posedge clk) begin
    core_en_q <= hif.hash_cmd[2];
    if (hif.hash_cmd[3]) begin
      core_hash <= 32'd5381;
      core_busy <= 1'b0;
    end else if (core_busy) begin
      core_hash <= core_hash * 33 + {25'd0, core_char};
      if (core_idx == hif.hash_cmd[1:0]) core_busy <= 1'b0;
      else core_idx <= core_idx + 2'd1;
    end else if (hif.hash_cmd[2] && !core_en_q && !core_dead) begin
      core_busy <= 1'b1;
      core_idx  <= 2'd0;
    end
  end

  assign hif.hash_busy  = core_busy;
  assign hif.hash_value = core_hash;

  // Bus monitor: records each enable rising edge (one per issued word).
  int          n_words = 0;
  int          en_cycles = 0;
  logic        en_prev = 1'b0;
  logic [1:0]  word_len [8];
  logic [27:0] word_data [8];

  always @(negedge clk) begin
    if (hif.hash_cmd[2]) en_cycles++;
    if (hif.hash_cmd[2] && !en_prev && n_words < 8) begin
      word_len[n_words]  = hif.hash_cmd[1:0];
      word_data[n_words] = hif.hash_data;
      n_words++;
    end
    en_prev = hif.hash_cmd[2];
  end

  task automatic put_byte(input logic [7:0] b, input logic last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = b;
    s_last  = last;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!s_ready) begin
      n_errors++;
      $display("FAIL byte_accept: s_ready=%0b after %0d cycles, required 1", s_ready, n);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) put_byte(s[i], i == s.len() - 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!digest_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!digest_valid) begin
      n_errors++;
      $display("FAIL digest_wait: digest_valid=0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic take_digest();
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    n_checks++;
    if (digest_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL digest_drop: digest_valid=%0b, required 0", digest_valid);
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({s_ready, digest_valid, err_timeout, err_nonascii} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b, required 0000",
               {s_ready, digest_valid, err_timeout, err_nonascii});
    end
    n_checks++;
    if (hif.hash_cmd !== 4'b0000 || hif.hash_data !== 28'd0) begin
      n_errors++;
      $display("FAIL reset_bus: cmd=%h data=%h, required 0/0", hif.hash_cmd, hif.hash_data);
    end
    n_checks++;
    if (digest !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_digest: got %h, required 0", digest);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_a();
    n_words = 0;
    send_str("a");
    wait_done();
    n_checks++;
    if (n_words !== 1 || word_len[0] !== 2'd0) begin
      n_errors++;
      $display("FAIL a_words: words=%0d len=%0d, required 1/0", n_words, word_len[0]);
    end
    n_checks++;
    if (digest !== 32'd177670) begin
      n_errors++;
      $display("FAIL a_digest: got %0d, required 177670", digest);
    end
    n_checks++;
    if ({err_timeout, err_nonascii} !== 2'b00) begin
      n_errors++;
      $display("FAIL a_errs: got %b, required 00", {err_timeout, err_nonascii});
    end
    take_digest();
  endtask

  task automatic test_abc();
    n_words = 0;
    send_str("abc");
    wait_done();
    n_checks++;
    if (n_words !== 1 || word_len[0] !== 2'd2) begin
      n_errors++;
      $display("FAIL abc_words: words=%0d len=%0d, required 1/2", n_words, word_len[0]);
    end
    n_checks++;
    if (word_data[0] !== {7'h00, 7'h63, 7'h62, 7'h61}) begin
      n_errors++;
      $display("FAIL abc_data: got %h, required %h", word_data[0], {7'h00, 7'h63, 7'h62, 7'h61});
    end
    n_checks++;
    if (digest !== 32'd193485963) begin
      n_errors++;
      $display("FAIL abc_digest: got %0d, required 193485963", digest);
    end
    take_digest();
  endtask

  task automatic test_back_to_back();
    n_words = 0;
    send_str("hello");
    wait_done();
    n_checks++;
    if (n_words !== 2) begin
      n_errors++;
      $display("FAIL hello_words: enable rising edges=%0d, required 2", n_words);
    end
    n_checks++;
    if (word_len[0] !== 2'd3 || word_len[1] !== 2'd0) begin
      n_errors++;
      $display("FAIL hello_lens: got %0d,%0d, required 3,0", word_len[0], word_len[1]);
    end
    n_checks++;
    if (digest !== 32'h0F923099) begin
      n_errors++;
      $display("FAIL hello_digest: got %h, required 0f923099", digest);
    end
    take_digest();
  endtask

  task automatic test_nonascii();
    put_byte(8'hE1, 1'b1);
    wait_done();
    n_checks++;
    if (err_nonascii !== 1'b1 || err_timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL na_flags: nonascii=%0b timeout=%0b, required 1/0", err_nonascii, err_timeout);
    end
    n_checks++;
    if (digest !== 32'd177670) begin
      n_errors++;
      $display("FAIL na_digest: got %0d, required 177670", digest);
    end
    take_digest();
  endtask

  task automatic test_timeout();
    core_dead = 1'b1;
    en_cycles = 0;
    send_str("a");
    wait_done();
    n_checks++;
    if (err_timeout !== 1'b1) begin
      n_errors++;
      $display("FAIL tmo_flag: got %0b, required 1", err_timeout);
    end
    n_checks++;
    if (en_cycles !== TIMEOUT) begin
      n_errors++;
      $display("FAIL tmo_cycles: enable high %0d cycles, required %0d", en_cycles, TIMEOUT);
    end
    n_checks++;
    if (hif.hash_cmd !== 4'b0000) begin
      n_errors++;
      $display("FAIL tmo_cmd: got %b, required 0000", hif.hash_cmd);
    end
    n_checks++;
    if (digest !== 32'd5381) begin
      n_errors++;
      $display("FAIL tmo_digest: got %0d, required 5381", digest);
    end
    take_digest();
    core_dead = 1'b0;
  endtask

  task automatic test_hold();
    send_str("a");
    wait_done();
    s_valid = 1'b1;
    s_data  = 8'h61;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (digest !== 32'd177670 || s_ready !== 1'b0 || digest_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL hold_%0d: digest=%0d s_ready=%0b valid=%0b, required 177670/0/1",
                 i, digest, s_ready, digest_valid);
      end
    end
    s_valid = 1'b0;
    take_digest();
  endtask

  task automatic test_reset_mid();
    put_byte("h", 1'b0);
    put_byte("e", 1'b0);
    put_byte("l", 1'b0);
    put_byte("l", 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s_ready, digest_valid, err_timeout, err_nonascii} !== 4'b0000) begin
      n_errors++;
      $display("FAIL rst_mid_flags: got %b, required 0000",
               {s_ready, digest_valid, err_timeout, err_nonascii});
    end
    n_checks++;
    if (hif.hash_cmd !== 4'b0000 || hif.hash_data !== 28'd0 || digest !== 32'd0) begin
      n_errors++;
      $display("FAIL rst_mid_bus: cmd=%h data=%h digest=%h, required 0/0/0",
               hif.hash_cmd, hif.hash_data, digest);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send_str("a");
    wait_done();
    n_checks++;
    if (digest !== 32'd177670) begin
      n_errors++;
      $display("FAIL rst_mid_digest: got %0d, required 177670", digest);
    end
    take_digest();
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_abc();
    test_back_to_back();
    test_nonascii();
    test_timeout();
    test_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
